// File: rtl/tiny_bcd_scan.sv
// Scan controller that time-multiplexes one hex-to-7-segment decoder across DIGITS digits.
// Display value is double-buffered and swapped only at frame wrap; each slot opens with a blanking gap.
module tiny_bcd_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  lz_en,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame,
  output logic                  pending
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_q, frame_d;

  logic                  last_cnt;
  logic                  wrap;
  logic                  show;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     zero_above;
  logic                  zrun;

  assign last_cnt = (cnt_q == CW'(PRESCALE - 1));
  assign wrap     = last_cnt && (idx_q == IW'(DIGITS - 1));
  assign show     = (cnt_q >= CW'(BLANK));

  always_comb begin
    cnt_d     = last_cnt ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (last_cnt) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    // Active takes the shadow as it stood before this edge, so a load on the wrap edge lands next frame.
    active_d  = (wrap && pending_q) ? shadow_q : active_q;
    shadow_d  = load ? value : shadow_q;
    pending_d = pending_q;
    if (wrap) pending_d = 1'b0;
    if (load) pending_d = 1'b1;
    frame_d   = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
    end
  end

  always_comb begin
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) nib = active_q[4*i +: 4];
    end
  end

  // zero_above[i] is set when nibbles i..DIGITS-1 of the active value are all zero.
  always_comb begin
    zero_above = '0;
    zrun       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun          = zrun & (active_q[4*i +: 4] == 4'h0);
      zero_above[i] = zrun;
    end
  end

  always_comb begin
    digit_en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (show && (idx_q == IW'(i)) && !(lz_en && (i != 0) && zero_above[i]))
        digit_en[i] = 1'b1;
    end
  end

  assign A       = nib[0];
  assign B       = nib[1];
  assign C       = nib[2];
  assign D       = nib[3];
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_tiny_bcd_scan.sv
// Bench for tiny_bcd_scan (DIGITS=4, PRESCALE=8, BLANK=2): time-based reference model checked
// every cycle, plus literal expectations at hand-picked cycles.
module tb_tiny_bcd_scan;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = DIGITS * PRESCALE;

  logic                clk = 1'b0;
  logic                rst;
  logic                load;
  logic [4*DIGITS-1:0] value;
  logic                lz_en;
  logic                A, B, C, D;
  logic [DIGITS-1:0]   digit_en;
  logic                frame;
  logic                pending;

  int total = 0;
  int bad   = 0;

  // reference state: cycles since reset release plus the buffered display words
  int                  t = 0;
  logic                m_valid = 1'b0;
  logic [4*DIGITS-1:0] m_shadow = '0;
  logic [4*DIGITS-1:0] m_active = '0;
  logic                m_pending = 1'b0;

  tiny_bcd_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .lz_en(lz_en),
    .A(A), .B(B), .C(C), .D(D), .digit_en(digit_en), .frame(frame), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      t = 0; m_shadow = '0; m_active = '0; m_pending = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (t % FRAME == FRAME - 1) begin
        if (m_pending) m_active = m_shadow;
        m_pending = 1'b0;
      end
      if (load) begin
        m_shadow  = value;
        m_pending = 1'b1;
      end
      t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  function automatic int nib_out();
    return int'({D, C, B, A});
  endfunction

  // per-cycle comparison against the model, plus one-hot and blanking-gap monitor
  initial begin
    int                  cnt, idx, zero_run;
    logic [4*DIGITS-1:0] upper;
    logic [DIGITS-1:0]   exp_en, last_en;
    logic                sup;
    zero_run = 100;
    last_en  = '0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        cnt    = t % PRESCALE;
        idx    = (t / PRESCALE) % DIGITS;
        upper  = m_active >> (4 * idx);
        sup    = (idx != 0) && lz_en && (upper == '0);
        exp_en = (cnt >= BLANK && !sup) ? (DIGITS'(1) << idx) : '0;
        check("digit_en", int'(digit_en), int'(exp_en));
        check("nibble", nib_out(), int'(upper[3:0]));
        check("frame", int'(frame), int'(t > 0 && t % FRAME == 0));
        check("pending", int'(pending), int'(m_pending));
        check("onehot0", int'($onehot0(digit_en)), 1);
        if (digit_en != '0) begin
          if (last_en != '0 && digit_en != last_en)
            check("blank_gap", int'(zero_run >= BLANK), 1);
          last_en  = digit_en;
          zero_run = 0;
        end else begin
          zero_run++;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; lz_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    // reset release and first slots
    check("c0_en", int'(digit_en), 4'b0000);
    check("c0_nib", nib_out(), 0);
    check("c0_frame", int'(frame), 0);
    check("c0_pend", int'(pending), 0);
    run_to(2);   check("c2_en", int'(digit_en), 4'b0001);
    run_to(5);   load = 1'b1; value = 16'h1234; tick(); load = 1'b0;
    check("c6_pend", int'(pending), 1);
    check("c6_nib", nib_out(), 0);
    run_to(10);  check("c10_en", int'(digit_en), 4'b0010);
    check("c10_nib", nib_out(), 0);
    // first frame wrap takes 1234
    run_to(32);  check("c32_frame", int'(frame), 1);
    check("c32_pend", int'(pending), 0);
    check("c32_nib", nib_out(), 4'h4);
    check("c32_en", int'(digit_en), 4'b0000);
    run_to(34);  check("c34_en", int'(digit_en), 4'b0001);
    run_to(42);  check("c42_nib", nib_out(), 4'h3);
    run_to(50);  check("c50_nib", nib_out(), 4'h2);
    run_to(56);  load = 1'b1; value = 16'h0050; tick(); load = 1'b0; lz_en = 1'b1;
    run_to(58);  check("c58_nib", nib_out(), 4'h1);
    check("c58_en", int'(digit_en), 4'b1000);
    // leading-zero suppression on 0050
    run_to(66);  check("lz_d0_en", int'(digit_en), 4'b0001);
    check("lz_d0_nib", nib_out(), 0);
    run_to(74);  check("lz_d1_en", int'(digit_en), 4'b0010);
    check("lz_d1_nib", nib_out(), 4'h5);
    run_to(82);  check("lz_d2_en", int'(digit_en), 4'b0000);
    run_to(90);  check("lz_d3_en", int'(digit_en), 4'b0000);
    load = 1'b1; value = 16'h0000; tick(); load = 1'b0;
    run_to(98);  check("lz0_d0_en", int'(digit_en), 4'b0001);
    run_to(106); check("lz0_d1_en", int'(digit_en), 4'b0000);
    // load on the wrap edge while pending
    lz_en = 1'b0;
    load = 1'b1; value = 16'h1234; tick(); load = 1'b0;
    run_to(127); load = 1'b1; value = 16'hAAAA; tick(); load = 1'b0;
    check("w128_pend", int'(pending), 1);
    check("w128_nib", nib_out(), 4'h4);
    check("w128_frame", int'(frame), 1);
    run_to(160); check("w160_nib", nib_out(), 4'hA);
    check("w160_pend", int'(pending), 0);
    // reset mid-slot with a pending value
    run_to(162); load = 1'b1; value = 16'h5678; tick(); load = 1'b0;
    run_to(181); check("r_pre_pend", int'(pending), 1);
    check("r_pre_en", int'(digit_en), 4'b0100);
    rst = 1'b1; tick();
    check("r_en", int'(digit_en), 4'b0000);
    check("r_nib", nib_out(), 0);
    check("r_pend", int'(pending), 0);
    rst = 1'b0;
    run_to(2);   check("r_c2_en", int'(digit_en), 4'b0001);
    // random loads and lz_en over three frames
    repeat (3 * FRAME) begin
      load  = ($urandom_range(0, 3) == 0);
      value = 16'($urandom);
      lz_en = 1'($urandom_range(0, 1));
      tick();
    end
    load = 1'b0; lz_en = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
